// File: rtl/cpu_pkg.sv
// Shared control-flow decode constants and types for the fetch stage.
package cpu_pkg;

  localparam int CPU_ADDR_W = 12;

  localparam logic [2:0] OP_BR  = 3'b101;
  localparam logic [4:0] OP_JMP = 5'b11100;
  localparam logic [4:0] OP_JSB = 5'b11101;
  localparam logic [5:0] OP_RET = 6'b111100;

  typedef enum logic [1:0] {
    BR_Z  = 2'b00,
    BR_NZ = 2'b01,
    BR_C  = 2'b10,
    BR_NC = 2'b11
  } br_cond_t;

  typedef logic [CPU_ADDR_W-1:0] addr_t;

endpackage

// File: rtl/fetch_pc_unit_if.sv
// Fetch-stage bus: instruction memory address/data plus datapath flags and stall.
// stall=1 freezes PC and RAS on the next edge; there is no other flow control.
interface fetch_pc_unit_if #(
  parameter int ADDR_W  = 12,
  parameter int INSTR_W = 19
);
  logic               stall;
  logic [INSTR_W-1:0] instruction;
  logic               zero_flag;
  logic               carry_flag;
  logic [ADDR_W-1:0]  address;
  logic [ADDR_W-1:0]  pc_plus1;
  logic               branch_taken;
  logic               ras_err;

  modport master (
    input  stall, instruction, zero_flag, carry_flag,
    output address, pc_plus1, branch_taken, ras_err
  );

  modport slave (
    output stall, instruction, zero_flag, carry_flag,
    input  address, pc_plus1, branch_taken, ras_err
  );
endinterface

// File: rtl/fetch_pc_unit_return_stack.sv
// Return-address LIFO. Push when full drops the oldest entry; pop when empty yields 0.
module return_stack #(
  parameter int DEPTH = 4,
  parameter int W     = 12
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] push_data,
  output logic [W-1:0] pop_data,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);
  localparam int SP_W  = $clog2(DEPTH + 1);
  localparam int IDX_W = $clog2(DEPTH);

  logic [W-1:0]     r_mem [DEPTH];
  logic [SP_W-1:0]  r_sp;
  logic [SP_W-1:0]  w_sp_m1;
  logic [IDX_W-1:0] w_rd_idx;
  logic [IDX_W-1:0] w_wr_idx;

  assign w_sp_m1  = r_sp - SP_W'(1);
  assign w_rd_idx = w_sp_m1[IDX_W-1:0];
  assign w_wr_idx = r_sp[IDX_W-1:0];

  assign full     = (r_sp == SP_W'(DEPTH));
  assign empty    = (r_sp == '0);
  assign ovf      = push & full;
  assign unf      = pop & empty;
  assign pop_data = empty ? '0 : r_mem[w_rd_idx];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      if (full) begin
        // Shift out the oldest entry so the newest always sits at the top.
        for (int i = 0; i < DEPTH - 1; i++) r_mem[i] <= r_mem[i+1];
        r_mem[DEPTH-1] <= push_data;
      end else begin
        r_mem[w_wr_idx] <= push_data;
        r_sp            <= r_sp + SP_W'(1);
      end
    end else if (pop && !empty) begin
      r_sp <= w_sp_m1;
    end
  end
endmodule

// File: rtl/fetch_pc_unit.sv
// PC / fetch sequencer with control-flow decode and a return-address stack.
// Optional FETCH_RAS_ERR_EN: sticky RAS error flag and trap restart on RET underflow.
module fetch_pc_unit
  import cpu_pkg::*;
#(
  parameter int               ADDR_W    = 12,
  parameter int               INSTR_W   = 19,
  parameter int               RAS_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  fetch_pc_unit_if.master  bus
);
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  w_pc_plus1;
  logic [ADDR_W-1:0]  w_next_pc;
  logic [ADDR_W-1:0]  w_offset;
  logic [ADDR_W-1:0]  w_pop_data;
  logic [INSTR_W-1:0] w_instr;
  logic               w_is_br, w_is_jmp, w_is_jsb, w_is_ret;
  logic               w_cond_true, w_taken;
  logic               w_push, w_pop;
  logic               w_full, w_empty, w_ovf, w_unf;
  logic               w_unused;
  br_cond_t           w_cond;

  assign w_instr    = bus.instruction;
  assign w_pc_plus1 = r_pc + ADDR_W'(1);
  assign w_is_br    = (w_instr[18:16] == OP_BR);
  assign w_is_jmp   = (w_instr[18:14] == OP_JMP);
  assign w_is_jsb   = (w_instr[18:14] == OP_JSB);
  assign w_is_ret   = (w_instr[18:13] == OP_RET);
  assign w_cond     = br_cond_t'(w_instr[15:14]);
  assign w_offset   = {{(ADDR_W-8){w_instr[7]}}, w_instr[7:0]};

  always_comb begin
    w_cond_true = 1'b0;
    case (w_cond)
      BR_Z:    w_cond_true =  bus.zero_flag;
      BR_NZ:   w_cond_true = ~bus.zero_flag;
      BR_C:    w_cond_true =  bus.carry_flag;
      BR_NC:   w_cond_true = ~bus.carry_flag;
      default: w_cond_true = 1'b0;
    endcase
  end

  always_comb begin
    w_next_pc = w_pc_plus1;
    w_taken   = 1'b0;
    w_push    = 1'b0;
    w_pop     = 1'b0;
    if (w_is_br && w_cond_true) begin
      w_taken   = 1'b1;
      w_next_pc = w_pc_plus1 + w_offset;
    end else if (w_is_jmp) begin
      w_taken   = 1'b1;
      w_next_pc = w_instr[ADDR_W-1:0];
    end else if (w_is_jsb) begin
      w_taken   = 1'b1;
      w_push    = ~bus.stall;
      w_next_pc = w_instr[ADDR_W-1:0];
    end else if (w_is_ret) begin
      w_taken   = 1'b1;
      w_pop     = ~bus.stall;
      w_next_pc = w_pop_data;
`ifdef FETCH_RAS_ERR_EN
      if (w_empty) w_next_pc = RESET_PC;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pc <= RESET_PC;
    else if (!bus.stall) r_pc <= w_next_pc;
  end

  return_stack #(.DEPTH(RAS_DEPTH), .W(ADDR_W)) u_ras (
    .clk       (clk),
    .rst_n     (rst),
    .push      (w_push),
    .pop       (w_pop),
    .push_data (w_pc_plus1),
    .pop_data  (w_pop_data),
    .full      (w_full),
    .empty     (w_empty),
    .ovf       (w_ovf),
    .unf       (w_unf)
  );

`ifdef FETCH_RAS_ERR_EN
  logic r_ras_err;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_ras_err <= 1'b0;
    else if (w_ovf || w_unf) r_ras_err <= 1'b1;
  end
  assign bus.ras_err = r_ras_err;
  assign w_unused    = ^{w_instr[12:8], w_full};
`else
  assign bus.ras_err = 1'b0;
  assign w_unused    = ^{w_instr[12:8], w_full, w_empty, w_ovf, w_unf};
`endif

  assign bus.address      = r_pc;
  assign bus.pc_plus1     = w_pc_plus1;
  assign bus.branch_taken = w_taken;
endmodule
